// File: rtl/coreaxitoahbl_wstrb_gen_pkg.sv
// Shared definitions for the AXI-to-AHB-Lite write-strobe path: strobe index widths,
// FSM encoding and the largest legal burst.
package coreaxitoahbl_wstrb_gen_pkg;

    localparam int unsigned STRB_IDX_W_64   = 3;
    localparam int unsigned STRB_IDX_W_32   = 2;
    localparam int unsigned MAX_BURST_BYTES = 4096;

    typedef enum logic {
        IDLE = 1'b0,
        BEAT = 1'b1
    } state_t;

    function automatic int unsigned strb_idx_w(input int unsigned dwidth);
        return (dwidth == 64) ? STRB_IDX_W_64 : STRB_IDX_W_32;
    endfunction

endpackage

// File: rtl/coreaxitoahbl_strb_mask.sv
// Contiguous byte-lane mask: i_n ones starting at lane i_offset.
module coreaxitoahbl_strb_mask #(
    parameter int STRBW = 8,
    parameter int IDXW  = 3
) (
    input  logic [IDXW-1:0]  i_offset,
    input  logic [3:0]       i_n,
    output logic [STRBW-1:0] o_mask
);

    always_comb begin
        o_mask = '0;
        for (int i = 0; i < STRBW; i++) begin
            if ((i >= int'(i_offset)) && (i < int'(i_offset) + int'(i_n))) begin
                o_mask[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/coreaxitoahbl_wstrb_gen.sv
// Burst write-strobe generator: turns (start offset, byte count) into one registered
// contiguous WSTRB mask plus byte count per data beat.
module coreaxitoahbl_wstrb_gen
    import coreaxitoahbl_wstrb_gen_pkg::*;
#(
    parameter int AXI_DWIDTH    = 64,
    parameter int AXI_STRBWIDTH = 8,
    parameter int BYTECNT_WIDTH = 13
) (
    input  logic                     ACLK,
    input  logic                     ARESET,
    input  logic                     reqValid,
    output logic                     reqReady,
    input  logic [2:0]               reqAddr,
    input  logic [BYTECNT_WIDTH-1:0] reqBytes,
    output logic                     beatValid,
    input  logic                     beatReady,
    output logic [AXI_STRBWIDTH-1:0] beatStrb,
    output logic [3:0]               beatBytes,
    output logic                     beatLast,
    output logic                     busy
);

    localparam int IDXW = strb_idx_w(AXI_DWIDTH);

    state_t                     r_state;
    logic [BYTECNT_WIDTH-1:0]   r_remaining;
    logic [AXI_STRBWIDTH-1:0]   r_strb;
    logic [3:0]                 r_bytes;
    logic                       r_last;

    logic [IDXW-1:0]            w_load_off;
    logic [BYTECNT_WIDTH-1:0]   w_load_rem;
    logic [3:0]                 w_room;
    logic [3:0]                 w_n;
    logic                       w_last;
    logic [AXI_STRBWIDTH-1:0]   w_mask;
    logic                       w_unused;

    // Beat outputs are flops, so the next beat is computed ahead of time. The start offset
    // only shapes the first beat; every later beat starts at lane 0, so the offset lives
    // on only inside the registered strobe.
    assign w_load_off = (r_state == IDLE) ? reqAddr[IDXW-1:0] : '0;
    assign w_load_rem = (r_state == IDLE) ? reqBytes
                                          : r_remaining - BYTECNT_WIDTH'(r_bytes);
    assign w_room     = 4'(AXI_STRBWIDTH) - 4'(w_load_off);
    assign w_n        = (w_load_rem < BYTECNT_WIDTH'(w_room)) ? w_load_rem[3:0] : w_room;
    assign w_last     = (w_load_rem == BYTECNT_WIDTH'(w_n));
    assign w_unused   = ^reqAddr;

    coreaxitoahbl_strb_mask #(
        .STRBW (AXI_STRBWIDTH),
        .IDXW  (IDXW)
    ) u_strb_mask (
        .i_offset (w_load_off),
        .i_n      (w_n),
        .o_mask   (w_mask)
    );

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state     <= IDLE;
            r_remaining <= '0;
            r_strb      <= '0;
            r_bytes     <= '0;
            r_last      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (reqValid && (reqBytes != '0)) begin
                        r_state     <= BEAT;
                        r_remaining <= w_load_rem;
                        r_strb      <= w_mask;
                        r_bytes     <= w_n;
                        r_last      <= w_last;
                    end
                end
                BEAT: begin
                    if (beatReady) begin
                        if (r_last) begin
                            r_state     <= IDLE;
                            r_remaining <= '0;
                            r_strb      <= '0;
                            r_bytes     <= '0;
                            r_last      <= 1'b0;
                        end else begin
                            r_remaining <= w_load_rem;
                            r_strb      <= w_mask;
                            r_bytes     <= w_n;
                            r_last      <= w_last;
                        end
                    end
                end
            endcase
        end
    end

    assign reqReady  = (r_state == IDLE);
    assign beatValid = (r_state == BEAT);
    assign busy      = (r_state == BEAT);
    assign beatStrb  = r_strb;
    assign beatBytes = r_bytes;
    assign beatLast  = r_last;

endmodule

// File: tb/tb_coreaxitoahbl_wstrb_gen.sv
// Self-checking bench for coreaxitoahbl_wstrb_gen: directed table, reset/zero-length
// corners and randomized bursts against a byte-count reference model (64- and 32-bit).
module tb_coreaxitoahbl_wstrb_gen;
    import coreaxitoahbl_wstrb_gen_pkg::*;

    typedef struct packed {
        logic [7:0] strb;
        logic [3:0] cnt;
        logic       last;
    } beat_t;

    typedef struct packed {
        logic        is32;
        logic [2:0]  addr;
        logic [12:0] bytes;
        logic [2:0]  stall;
        logic [1:0]  nb;
        beat_t [2:0] beats;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [2:0]  req_addr = '0;
    logic [12:0] req_bytes = '0;
    logic        beat_ready = 1'b0;

    logic        rr64, bv64, bl64, busy64;
    logic [7:0]  bs64;
    logic [3:0]  bb64;
    logic        rr32, bv32, bl32, busy32;
    logic [3:0]  bs32;
    logic [3:0]  bb32;

    int checks = 0;
    int failures = 0;
    beat_t exp_q[$];
    vec_t tbl[6];

    always #5 clk = ~clk;

    coreaxitoahbl_wstrb_gen #(
        .AXI_DWIDTH    (64),
        .AXI_STRBWIDTH (8),
        .BYTECNT_WIDTH (13)
    ) u_dut64 (
        .ACLK      (clk),
        .ARESET    (rst),
        .reqValid  (req_valid),
        .reqReady  (rr64),
        .reqAddr   (req_addr),
        .reqBytes  (req_bytes),
        .beatValid (bv64),
        .beatReady (beat_ready),
        .beatStrb  (bs64),
        .beatBytes (bb64),
        .beatLast  (bl64),
        .busy      (busy64)
    );

    coreaxitoahbl_wstrb_gen #(
        .AXI_DWIDTH    (32),
        .AXI_STRBWIDTH (4),
        .BYTECNT_WIDTH (13)
    ) u_dut32 (
        .ACLK      (clk),
        .ARESET    (rst),
        .reqValid  (req_valid),
        .reqReady  (rr32),
        .reqAddr   (req_addr),
        .reqBytes  (req_bytes),
        .beatValid (bv32),
        .beatReady (beat_ready),
        .beatStrb  (bs32),
        .beatBytes (bb32),
        .beatLast  (bl32),
        .busy      (busy32)
    );

    always @(posedge clk) begin
        if (req_valid && !rst) begin
            assert (req_bytes <= 13'(MAX_BURST_BYTES))
            else $error("reqBytes %0d beyond the legal maximum", req_bytes);
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: each beat takes as many bytes as fit between the current lane and the
    // end of the word, or whatever is left; only the first beat starts off lane 0.
    task automatic model(input logic is32, input logic [2:0] addr, input int bytes);
        int w;
        int off;
        int rem;
        int n;
        beat_t b;
        w   = is32 ? 4 : 8;
        off = int'(addr) % w;
        rem = bytes;
        exp_q = {};
        while (rem > 0) begin
            n = (w - off < rem) ? (w - off) : rem;
            b.strb = 8'(((1 << n) - 1) << off);
            b.cnt  = 4'(n);
            b.last = (rem == n);
            exp_q.push_back(b);
            rem -= n;
            off = 0;
        end
    endtask

    function automatic vec_t mk(input logic is32, input logic [2:0] a, input int b,
                                input int st, input int nb,
                                input logic [7:0] s0, input int c0, input logic l0,
                                input logic [7:0] s1, input int c1, input logic l1,
                                input logic [7:0] s2, input int c2, input logic l2);
        vec_t v;
        v.is32  = is32;
        v.addr  = a;
        v.bytes = 13'(b);
        v.stall = 3'(st);
        v.nb    = 2'(nb);
        v.beats[0] = '{strb: s0, cnt: 4'(c0), last: l0};
        v.beats[1] = '{strb: s1, cnt: 4'(c1), last: l1};
        v.beats[2] = '{strb: s2, cnt: 4'(c2), last: l2};
        return v;
    endfunction

    task automatic check_idle(input logic is32, input string tag);
        check({tag, "_valid"}, 32'(is32 ? bv32 : bv64), 0);
        check({tag, "_ready"}, 32'(is32 ? rr32 : rr64), 1);
        check({tag, "_busy"}, 32'(is32 ? busy32 : busy64), 0);
    endtask

    // Runs one burst against exp_q; called just after a rising edge.
    task automatic do_burst(input logic is32, input logic [2:0] addr, input logic [12:0] bytes,
                            input int first_stall, input int stall_pct);
        int stall;
        logic [7:0] strb;
        logic [3:0] cnt;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("req_ready_before", 32'(is32 ? rr32 : rr64), 1);
        req_valid = 1'b1;
        req_addr  = addr;
        req_bytes = bytes;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int k = 0; k < exp_q.size(); k++) begin
            stall = (k == 0) ? first_stall : 0;
            if (stall_pct > 0 && $urandom_range(0, 99) < stall_pct) begin
                stall += $urandom_range(1, 3);
            end
            for (int s = 0; s <= stall; s++) begin
                beat_ready = (s == stall);
                strb = is32 ? {4'h0, bs32} : bs64;
                cnt  = is32 ? bb32 : bb64;
                check("beat_valid", 32'(is32 ? bv32 : bv64), 1);
                check("beat_req_ready", 32'(is32 ? rr32 : rr64), 0);
                check("beat_busy", 32'(is32 ? busy32 : busy64), 1);
                check("beat_strb", 32'(strb), 32'(exp_q[k].strb));
                check("beat_bytes", 32'(cnt), 32'(exp_q[k].cnt));
                check("beat_last", 32'(is32 ? bl32 : bl64), 32'(exp_q[k].last));
                check("popcount", 32'($countones(strb)), 32'(cnt));
                @(posedge clk); #1;
            end
        end
        beat_ready = 1'b0;
        check_idle(is32, "after_burst");
    endtask

    task automatic run_vec(input vec_t v);
        exp_q = {};
        for (int k = 0; k < int'(v.nb); k++) exp_q.push_back(v.beats[k]);
        do_burst(v.is32, v.addr, v.bytes, int'(v.stall), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        is32;
        logic [2:0]  addr;
        int          bytes;

        tbl[0] = mk(0, 0, 16, 0, 2, 8'hFF, 8, 0, 8'hFF, 8, 1, 8'h00, 0, 0);
        tbl[1] = mk(0, 5, 10, 0, 2, 8'hE0, 3, 0, 8'h7F, 7, 1, 8'h00, 0, 0);
        tbl[2] = mk(0, 2, 3,  0, 1, 8'h1C, 3, 1, 8'h00, 0, 0, 8'h00, 0, 0);
        tbl[3] = mk(0, 0, 24, 4, 3, 8'hFF, 8, 0, 8'hFF, 8, 0, 8'hFF, 8, 1);
        tbl[4] = mk(1, 3, 6,  0, 3, 8'h08, 1, 0, 8'h0F, 4, 0, 8'h01, 1, 1);
        tbl[5] = mk(0, 1, 7,  0, 1, 8'hFE, 7, 1, 8'h00, 0, 0, 8'h00, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_idle(0, "reset64");
        check_idle(1, "reset32");
        check("reset_strb", 32'(bs64), 0);
        check("reset_bytes", 32'(bb64), 0);
        check("reset_last", 32'(bl64), 0);

        for (int i = 0; i < 5; i++) begin
            run_vec(tbl[i]);
            if (i == 2) begin
                // Zero-length request must be ignored.
                req_valid = 1'b1;
                req_addr  = 3'd4;
                req_bytes = '0;
                for (int c = 0; c < 3; c++) begin
                    @(posedge clk); #1;
                    check_idle(0, "zero_len");
                end
                req_valid = 1'b0;
            end
        end

        // Reset in the middle of beat 2 of a 4-beat burst, with beatReady also high.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        req_valid = 1'b1;
        req_addr  = 3'd0;
        req_bytes = 13'd32;
        @(posedge clk); #1;
        req_valid  = 1'b0;
        beat_ready = 1'b1;
        @(posedge clk); #1;
        beat_ready = 1'b0;
        check("mid_beat2_strb", 32'(bs64), 32'hFF);
        check("mid_beat2_last", 32'(bl64), 0);
        rst = 1'b1;
        beat_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        beat_ready = 1'b0;
        check_idle(0, "mid_reset");
        check("mid_reset_strb", 32'(bs64), 0);
        @(posedge clk); #1;
        check_idle(0, "mid_reset_hold");
        run_vec(tbl[5]);

        for (int i = 0; i < 60; i++) begin
            is32  = 1'($urandom_range(0, 1));
            addr  = 3'($urandom_range(0, 7));
            bytes = (i % 15 == 7) ? int'($urandom_range(4000, 4096)) : int'($urandom_range(1, 40));
            model(is32, addr, bytes);
            do_burst(is32, addr, 13'(bytes), 0, 30);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
